// File: rtl/synaptic_weight_accumulator_pkg.sv
// Shared definitions for the synaptic weight accumulator and its neighbours
// in the conductance LIF neuron unit.
//   - state_t        : accumulator control states (IDLE / ACCUM / HOLD)
//   - SYN_EX/SYN_IN  : synapse-type encodings carried on SynType
//   - *_DEF          : default fixed-point widths (Q32.32)
//   - DATA_MAX/MIN   : saturation limits at the default data width
package synaptic_weight_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic SYN_EX = 1'b0;
  localparam logic SYN_IN = 1'b1;

  localparam int INTEGER_WIDTH_DEF   = 32;
  localparam int DATA_WIDTH_FRAC_DEF = 32;
  localparam int DATA_WIDTH_DEF      = INTEGER_WIDTH_DEF + DATA_WIDTH_FRAC_DEF;
  localparam int COUNT_WIDTH_DEF     = 12;

  localparam logic signed [DATA_WIDTH_DEF-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_DEF-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/synaptic_weight_accumulator_sat_add.sv
// sat_add: DATA_WIDTH-bit signed adder used on the excitatory and inhibitory
// accumulation paths.
// Configuration macro: WEIGHT_SAT_EN
//   defined   -> result clamps to the most positive/negative value on overflow
//   undefined -> plain two's-complement wrap-around
// Ports:
//   a, b : signed addends
//   sum  : signed result (combinational)
module sat_add
  import synaptic_weight_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sum
);

`ifdef WEIGHT_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Signed overflow only happens when both addends share a sign and the
  // wrapped result does not; the addend sign then picks the rail.
  function automatic logic signed [DATA_WIDTH-1:0] add_sat(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    logic signed [DATA_WIDTH-1:0] raw;
    raw = x + y;
    if ((x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) && (raw[DATA_WIDTH-1] != x[DATA_WIDTH-1]))
      return x[DATA_WIDTH-1] ? SUM_MIN : SUM_MAX;
    return raw;
  endfunction

  assign sum = add_sat(a, b);
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/synaptic_weight_accumulator.sv
// synaptic_weight_accumulator: per neuron and time step, sums a stream of
// (weight, synapse type) beats into separate excitatory and inhibitory
// signed fixed-point totals and hands them to the neuron update controller.
// Configuration macro: WEIGHT_SAT_EN (saturating instead of wrapping sums).
// Ports:
//   Clock, Reset                 : clock, synchronous active-high reset
//   Start, NoInput               : begin a step; NoInput skips straight to HOLD
//   WeightValid/WeightReady      : beat handshake (ready only in ACCUM)
//   Weight, SynType, WeightLast  : beat payload, type (0 ex / 1 in), last flag
//   ExWeightSum, InWeightSum     : registered signed sums
//   SumValid, SumAck             : result handshake (valid while in HOLD)
//   SynCount, CountOverflow      : beats accepted this step, sticky wrap flag
//   Busy                         : block is not IDLE
module synaptic_weight_accumulator
  import synaptic_weight_accumulator_pkg::*;
#(
  parameter int INTEGER_WIDTH   = INTEGER_WIDTH_DEF,
  parameter int DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          NoInput,
  input  logic                          WeightValid,
  output logic                          WeightReady,
  input  logic signed [DATA_WIDTH-1:0]  Weight,
  input  logic                          SynType,
  input  logic                          WeightLast,
  output logic signed [DATA_WIDTH-1:0]  ExWeightSum,
  output logic signed [DATA_WIDTH-1:0]  InWeightSum,
  output logic                          SumValid,
  input  logic                          SumAck,
  output logic [COUNT_WIDTH-1:0]        SynCount,
  output logic                          CountOverflow,
  output logic                          Busy
);

  state_t state, state_nxt;
  logic   clear;
  logic   accept;

  logic signed [DATA_WIDTH-1:0] ex_sum_p0, in_sum_p0;
  logic signed [DATA_WIDTH-1:0] ex_add, in_add;
  logic [COUNT_WIDTH-1:0]       count_p0;
  logic                         count_ovf_p0;

  assign accept = WeightValid && (state == ACCUM);

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          clear     = 1'b1;
          state_nxt = NoInput ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && WeightLast) state_nxt = HOLD;
      end
      HOLD: begin
        // Ack together with Start chains directly into the next step.
        if (SumAck) begin
          if (Start) begin
            clear     = 1'b1;
            state_nxt = NoInput ? HOLD : ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_ex_add (
    .a   (ex_sum_p0),
    .b   (Weight),
    .sum (ex_add)
  );

  sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_in_add (
    .a   (in_sum_p0),
    .b   (Weight),
    .sum (in_add)
  );

  // ---- accumulation register stage ----
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      ex_sum_p0 <= '0;
      in_sum_p0 <= '0;
    end else if (accept) begin
      if (SynType == SYN_EX) ex_sum_p0 <= ex_add;
      else                   in_sum_p0 <= in_add;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count_p0     <= '0;
      count_ovf_p0 <= 1'b0;
    end else if (accept) begin
      count_p0 <= count_p0 + COUNT_WIDTH'(1);
      if (&count_p0) count_ovf_p0 <= 1'b1;
    end
  end

  assign ExWeightSum   = ex_sum_p0;
  assign InWeightSum   = in_sum_p0;
  assign SynCount      = count_p0;
  assign CountOverflow = count_ovf_p0;
  assign SumValid      = (state == HOLD);
  assign WeightReady   = (state == ACCUM);
  assign Busy          = (state != IDLE);

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Bench for synaptic_weight_accumulator: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// step-level reference model. A second instance with a 2-bit counter shares
// the stimulus so the count wrap can be seen after a handful of beats.
module tb_synaptic_weight_accumulator;

  localparam int DW  = 64;
  localparam int CW  = 12;
  localparam int CW2 = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0, NoInput = 1'b0, WeightValid = 1'b0;
  logic SynType = 1'b0, WeightLast = 1'b0, SumAck = 1'b0;
  logic signed [DW-1:0] Weight = '0;

  logic                 a_ready, a_valid, a_ovf, a_busy;
  logic signed [DW-1:0] a_ex, a_in;
  logic [CW-1:0]        a_cnt;
  logic                 b_ready, b_valid, b_ovf, b_busy;
  logic signed [DW-1:0] b_ex, b_in;
  logic [CW2-1:0]       b_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 Clock = ~Clock;

  synaptic_weight_accumulator dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .NoInput(NoInput),
    .WeightValid(WeightValid), .WeightReady(a_ready), .Weight(Weight),
    .SynType(SynType), .WeightLast(WeightLast), .ExWeightSum(a_ex),
    .InWeightSum(a_in), .SumValid(a_valid), .SumAck(SumAck),
    .SynCount(a_cnt), .CountOverflow(a_ovf), .Busy(a_busy)
  );

  synaptic_weight_accumulator #(.COUNT_WIDTH(CW2)) dut_small (
    .Clock(Clock), .Reset(Reset), .Start(Start), .NoInput(NoInput),
    .WeightValid(WeightValid), .WeightReady(b_ready), .Weight(Weight),
    .SynType(SynType), .WeightLast(WeightLast), .ExWeightSum(b_ex),
    .InWeightSum(b_in), .SumValid(b_valid), .SumAck(SumAck),
    .SynCount(b_cnt), .CountOverflow(b_ovf), .Busy(b_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (per-step view) ----------------
  typedef enum {PH_IDLE, PH_COLLECT, PH_PRESENT} phase_t;
  phase_t               m_phase;
  logic signed [DW-1:0] m_ex, m_in;
  int                   m_beats;

  // Exact sum in a wider integer, then either clamp or keep the low bits.
  function automatic logic signed [DW-1:0] madd(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    logic signed [DW+1:0] wide;
    wide = (DW+2)'(a) + (DW+2)'(b);
`ifdef WEIGHT_SAT_EN
    if (wide > (DW+2)'(64'sh7FFF_FFFF_FFFF_FFFF)) return 64'sh7FFF_FFFF_FFFF_FFFF;
    if (wide < (DW+2)'(-64'sh7FFF_FFFF_FFFF_FFFF - 1)) return 64'sh8000_0000_0000_0000;
`endif
    return wide[DW-1:0];
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_phase <= PH_IDLE;
      m_ex    <= '0;
      m_in    <= '0;
      m_beats <= 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (Start) begin
          m_ex <= '0; m_in <= '0; m_beats <= 0;
          m_phase <= NoInput ? PH_PRESENT : PH_COLLECT;
        end
        PH_COLLECT: if (WeightValid) begin
          if (SynType) m_in <= madd(m_in, Weight);
          else         m_ex <= madd(m_ex, Weight);
          m_beats <= m_beats + 1;
          if (WeightLast) m_phase <= PH_PRESENT;
        end
        PH_PRESENT: if (SumAck) begin
          if (Start) begin
            m_ex <= '0; m_in <= '0; m_beats <= 0;
            m_phase <= NoInput ? PH_PRESENT : PH_COLLECT;
          end else begin
            m_phase <= PH_IDLE;
          end
        end
        default: m_phase <= PH_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge Clock) begin
    if (chk_on) begin
      chk("ready",    64'(a_ready), 64'(m_phase == PH_COLLECT));
      chk("busy",     64'(a_busy),  64'(m_phase != PH_IDLE));
      chk("valid",    64'(a_valid), 64'(m_phase == PH_PRESENT));
      chk("ex_sum",   a_ex, m_ex);
      chk("in_sum",   a_in, m_in);
      chk("count",    64'(a_cnt), 64'(m_beats % (1 << CW)));
      chk("ovf",      64'(a_ovf), 64'(m_beats >= (1 << CW)));
      chk("s_valid",  64'(b_valid), 64'(m_phase == PH_PRESENT));
      chk("s_ex_sum", b_ex, m_ex);
      chk("s_in_sum", b_in, m_in);
      chk("s_count",  64'(b_cnt), 64'(m_beats % (1 << CW2)));
      chk("s_ovf",    64'(b_ovf), 64'(m_beats >= (1 << CW2)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_step(input logic ni);
    Start = 1'b1; NoInput = ni;
    tick();
    Start = 1'b0; NoInput = 1'b0;
  endtask

  task automatic beat(input logic [63:0] w, input logic t, input logic last);
    WeightValid = 1'b1; Weight = w; SynType = t; WeightLast = last;
    tick();
    WeightValid = 1'b0; WeightLast = 1'b0;
  endtask

  task automatic ack();
    SumAck = 1'b1;
    tick();
    SumAck = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    while (!a_valid && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 64'(a_valid), 64'd1);
  endtask

  initial begin
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_ex",   a_ex, 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    Reset = 1'b0;
    tick();

    // basic accumulation
    start_step(1'b0);
    beat(64'h00000001_80000000, 1'b0, 1'b0);
    beat(64'hFFFFFFFF_C0000000, 1'b1, 1'b0);
    beat(64'h00000002_00000000, 1'b0, 1'b1);
    chk("basic_valid", 64'(a_valid), 64'd1);
    chk("basic_ex",    a_ex, 64'h00000003_80000000);
    chk("basic_in",    a_in, 64'hFFFFFFFF_C0000000);
    chk("basic_cnt",   64'(a_cnt), 64'd3);
    ack();
    chk("basic_idle",  64'(a_busy), 64'd0);

    // empty step
    start_step(1'b1);
    chk("empty_valid", 64'(a_valid), 64'd1);
    chk("empty_ex",    a_ex, 64'd0);
    chk("empty_cnt",   64'(a_cnt), 64'd0);
    ack();
    chk("empty_busy",  64'(a_busy), 64'd0);

    // gaps and stray Start pulses
    start_step(1'b0);
    beat(64'h00000001_00000000, 1'b0, 1'b0);
    tick(); tick();
    Start = 1'b1; tick(); Start = 1'b0;
    beat(64'h00000003_00000000, 1'b1, 1'b0);
    tick();
    beat(64'h00000000_80000000, 1'b0, 1'b1);
    wait_valid("gap_valid", 4);
    chk("gap_ex",  a_ex, 64'h00000001_80000000);
    chk("gap_in",  a_in, 64'h00000003_00000000);
    chk("gap_cnt", 64'(a_cnt), 64'd3);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("hold_start_valid", 64'(a_valid), 64'd1);
    chk("hold_start_ex",    a_ex, 64'h00000001_80000000);
    ack();

    // back-to-back ack + start
    start_step(1'b0);
    beat(64'h00000001_00000000, 1'b0, 1'b1);
    SumAck = 1'b1; Start = 1'b1;
    tick();
    SumAck = 1'b0; Start = 1'b0;
    chk("b2b_ready", 64'(a_ready), 64'd1);
    chk("b2b_ex",    a_ex, 64'd0);
    chk("b2b_cnt",   64'(a_cnt), 64'd0);
    beat(64'h00000000_40000000, 1'b1, 1'b1);
    ack();

    // sum overflow and small-counter wrap
    start_step(1'b0);
    beat(64'h7FFFFFFF_00000000, 1'b0, 1'b0);
    beat(64'h00000002_00000000, 1'b0, 1'b0);
`ifdef WEIGHT_SAT_EN
    chk("ovf_ex", a_ex, 64'h7FFFFFFF_FFFFFFFF);
`else
    chk("ovf_ex", a_ex, 64'h80000001_00000000);
`endif
    beat(64'd0, 1'b0, 1'b0);
    beat(64'd0, 1'b1, 1'b0);
    beat(64'd0, 1'b1, 1'b1);
    chk("small_cnt", 64'(b_cnt), 64'd1);
    chk("small_ovf", 64'(b_ovf), 64'd1);
    chk("big_cnt",   64'(a_cnt), 64'd5);
    chk("big_ovf",   64'(a_ovf), 64'd0);
    ack();

    // reset in the middle of accumulation
    start_step(1'b0);
    beat(64'h00000005_00000000, 1'b0, 1'b0);
    beat(64'h00000006_00000000, 1'b1, 1'b0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("mid_rst_ex",    a_ex, 64'd0);
    chk("mid_rst_in",    a_in, 64'd0);
    chk("mid_rst_cnt",   64'(a_cnt), 64'd0);
    chk("mid_rst_busy",  64'(a_busy), 64'd0);
    chk("mid_rst_ready", 64'(a_ready), 64'd0);
    start_step(1'b0);
    beat(64'h00000001_00000000, 1'b1, 1'b1);
    chk("after_rst_in", a_in, 64'h00000001_00000000);
    chk("after_rst_ex", a_ex, 64'd0);
    ack();

    // full-width counter wrap
    start_step(1'b0);
    WeightValid = 1'b1; Weight = 64'd1; SynType = 1'b0;
    for (int i = 0; i < (1 << CW); i++) tick();
    WeightLast = 1'b1;
    tick();
    WeightValid = 1'b0; WeightLast = 1'b0;
    chk("wrap_cnt", 64'(a_cnt), 64'd1);
    chk("wrap_ovf", 64'(a_ovf), 64'd1);
    chk("wrap_ex",  a_ex, 64'd4097);
    ack();

    // randomized traffic on every input
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: Weight = {$urandom, $urandom};
        1: Weight = {{32{r[31]}}, r};
        2: Weight = 64'h7FFFFFFF_F0000000 + 64'($urandom_range(0, 255));
        default: Weight = 64'h80000000_00000000 + 64'($urandom_range(0, 255));
      endcase
      WeightValid = ($urandom_range(0, 3) != 0);
      SynType     = $urandom_range(0, 1);
      WeightLast  = ($urandom_range(0, 5) == 0);
      Start       = ($urandom_range(0, 4) == 0);
      NoInput     = ($urandom_range(0, 5) == 0);
      SumAck      = ($urandom_range(0, 2) == 0);
      Reset       = ($urandom_range(0, 299) == 0);
      tick();
    end
    WeightValid = 1'b0; WeightLast = 1'b0; Start = 1'b0;
    NoInput = 1'b0; SumAck = 1'b0; Reset = 1'b0;
    tick(); tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synaptic_weight_accumulator.md
Name: synaptic_weight_accumulator

Overview:
- Upstream stage of the conductance LIF neuron unit; produces the per-neuron ExWeightSum/InWeightSum consumed by its synaptic integration path.
- Per time step, accepts a stream of (weight, synapse type) pairs from the synapse memory/router for one neuron.
- Accumulates excitatory and inhibitory weights separately in signed fixed point.
- Presents both sums to the neuron update controller through a valid/ack handshake.

Parameters:
- INTEGER_WIDTH, 32, integer bits of fixed-point data
- DATA_WIDTH_FRAC, 32, fractional bits of fixed-point data
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full signed data width
- COUNT_WIDTH, 12, width of the accepted-synapse counter

Ports:
- Clock  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin accumulation for a new neuron/time step
- NoInput  in  1  sampled with Start; neuron has zero incoming spikes this step
- WeightValid  in  1  weight beat valid
- WeightReady  out  1  block accepts a beat
- Weight  in  DATA_WIDTH  signed synaptic weight
- SynType  in  1  0 = excitatory, 1 = inhibitory
- WeightLast  in  1  final beat for this neuron
- ExWeightSum  out  DATA_WIDTH  signed excitatory sum
- InWeightSum  out  DATA_WIDTH  signed inhibitory sum
- SumValid  out  1  sums are final
- SumAck  in  1  consumer has taken the sums
- SynCount  out  COUNT_WIDTH  beats accepted this step
- CountOverflow  out  1  sticky: SynCount wrapped during this step
- Busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, clock Clock; highest priority, also mid-operation):
  - state=IDLE.
  - ExWeightSum, InWeightSum, SynCount = 0; SumValid, CountOverflow = 0.
  - Any partial accumulation is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - WeightReady=0; Weight beats are ignored.
  - Start=1 clears both sums, SynCount and CountOverflow.
  - NoInput=1 -> next state HOLD with zero sums; else -> ACCUM.
- ACCUM:
  - WeightReady=1.
  - A beat is accepted when WeightValid && WeightReady.
  - SynType=0 adds Weight to ExWeightSum; SynType=1 adds Weight to InWeightSum.
  - Each accepted beat increments SynCount; wrap from all-ones to 0 sets CountOverflow.
  - An accepted beat with WeightLast=1 -> next state HOLD. The sums registered that cycle include the last beat.
  - Start is ignored in ACCUM.
- HOLD:
  - SumValid=1; sums are stable; WeightReady=0.
  - SumAck -> IDLE and SumValid deasserts next cycle.
  - SumAck with Start in the same cycle: sums, count and overflow clear, and the block enters ACCUM directly, or HOLD if NoInput=1. No idle bubble.
  - Start without SumAck is ignored.
- Latency: SumValid rises on the cycle after the last beat is accepted, or after Start with NoInput=1.
- Throughput: one beat per clock.
- Arithmetic:
  - Full-width signed DATA_WIDTH addition, same Q format as Weight.
  - Default is two's-complement wrap (see Optional Feature).
- Outputs are registered; WeightReady and Busy are decoded from state only.
- Sums hold their last values in IDLE until the next Start.

Optional Feature:
- Macro WEIGHT_SAT_EN.
- Defined: each addition saturates to the most positive/negative DATA_WIDTH value on signed overflow. A saturated sum stays pinned until further beats bring it back in range.
- Undefined: plain wrap-around addition; no saturation logic.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ACCUM/HOLD);
  - SYN_EX=0 / SYN_IN=1 constants;
  - fixed-point width defaults;
  - DATA_MAX/DATA_MIN saturation constants, shared with other neuron units.
- One sub-module, sat_add: DATA_WIDTH signed adder with saturation bypass under WEIGHT_SAT_EN. It is instantiated twice (ex and in paths).

Test Plan:
- Basic accumulation: Start; beats ex 1.5 (0x00000001_80000000), in -0.25 (0xFFFFFFFF_C0000000), ex 2.0 with Last.
  -> ExWeightSum=0x00000003_80000000, InWeightSum=0xFFFFFFFF_C0000000, SynCount=3, SumValid one cycle after Last.
- Empty step: Start with NoInput=1.
  -> HOLD next cycle, both sums 0, SynCount 0; SumAck -> Busy=0 next cycle.
- Back-pressure/gaps: WeightValid toggled with idle cycles, Start pulsed during ACCUM and during HOLD without SumAck.
  -> sums equal a gap-free run; Start has no effect.
- Back-to-back: SumAck and Start in the same HOLD cycle.
  -> next cycle ACCUM, sums 0, WeightReady=1.
- Overflow: ex beats 0x7FFFFFFF_00000000 then 0x00000002_00000000.
  -> with WEIGHT_SAT_EN: 0x7FFFFFFF_FFFFFFFF; without: 0x80000001_00000000.
  -> COUNT_WIDTH=2 with 5 beats: CountOverflow=1, SynCount=1.
- Reset mid-ACCUM after 2 beats.
  -> next cycle all outputs 0, state IDLE; a new Start accumulates from zero.
